// File: rtl/aes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_pkg: shared encodings for the SPI slave and the AES CBC sequencer.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_WAIT  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT
    } seq_state_e;

    localparam int STAT_DONE    = 0;
    localparam int STAT_TIMEOUT = 1;
    localparam int STAT_OVERRUN = 2;

    // Command codes decoded by the SPI slave
    localparam logic [7:0] CMD_WRITE_KEY   = 8'h01;
    localparam logic [7:0] CMD_WRITE_IV    = 8'h02;
    localparam logic [7:0] CMD_WRITE_PT    = 8'h03;
    localparam logic [7:0] CMD_START       = 8'h04;
    localparam logic [7:0] CMD_READ_CT     = 8'h05;
    localparam logic [7:0] CMD_READ_STATUS = 8'h06;
    localparam logic [7:0] CMD_SOFT_RESET  = 8'hFF;

    function automatic logic [AES_BLOCK_W-1:0] cbc_chain_in(
        input logic [AES_BLOCK_W-1:0] pt,
        input logic [AES_BLOCK_W-1:0] prev
    );
        return pt ^ prev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_cbc_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_cbc_watchdog: clearable up-counter flagging TIMEOUT_CYCLES reached.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module aes_cbc_watchdog #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Saturates so a late enable can never wrap back below the limit
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != c_cnt_max)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/aes_cbc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_cbc_sequencer: CBC chaining, core handshake and watchdog for AES-128. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module aes_cbc_sequencer
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int BLOCK_W        = AES_BLOCK_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_encryption,
    input  logic               new_message,
    input  logic [BLOCK_W-1:0] plaintext,
    input  logic [BLOCK_W-1:0] key,
    input  logic [BLOCK_W-1:0] iv,
    output logic [BLOCK_W-1:0] ciphertext,
    output logic               encryption_done,
    output logic               busy,
    output logic [7:0]         status,
    output logic               core_start,
    output logic [BLOCK_W-1:0] core_key,
    output logic [BLOCK_W-1:0] core_block_in,
    input  logic               core_done,
    input  logic [BLOCK_W-1:0] core_block_out
);

    seq_state_e         state_q;
    logic [BLOCK_W-1:0] key_q;
    logic [BLOCK_W-1:0] block_q;
    logic [BLOCK_W-1:0] chain_q;
    logic [BLOCK_W-1:0] ciphertext_q;
    logic               chain_valid_q;
    logic               done_q;
    logic               timeout_q;
    logic               overrun_q;
    logic               core_start_q;

    logic               w_wd_clear;
    logic               w_wd_enable;
    logic               w_wd_expire;
    logic [BLOCK_W-1:0] w_chain_src;

    assign w_wd_clear  = (state_q == S_ISSUE);
    assign w_wd_enable = (state_q == S_WAIT);

    aes_cbc_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (w_wd_clear),
        .enable_i (w_wd_enable),
        .expire_o (w_wd_expire)
    );

    // A fresh message, or a chain broken by timeout/reset, restarts from the IV
    assign w_chain_src = (new_message || !chain_valid_q) ? iv : chain_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            key_q         <= '0;
            block_q       <= '0;
            chain_q       <= '0;
            ciphertext_q  <= '0;
            chain_valid_q <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            overrun_q     <= 1'b0;
            core_start_q  <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_encryption) begin
                        key_q        <= key;
                        block_q      <= cbc_chain_in(plaintext, w_chain_src);
                        done_q       <= 1'b0;
                        timeout_q    <= 1'b0;
                        if (new_message) begin
                            overrun_q <= 1'b0;
                        end
                        core_start_q <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (start_encryption) begin
                        overrun_q <= 1'b1;
                    end
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (start_encryption) begin
                        overrun_q <= 1'b1;
                    end
                    // Completion takes priority over a coincident expiry
                    if (core_done) begin
                        ciphertext_q  <= core_block_out;
                        chain_q       <= core_block_out;
                        chain_valid_q <= 1'b1;
                        done_q        <= 1'b1;
                        state_q       <= S_IDLE;
                    end else if (w_wd_expire) begin
                        timeout_q     <= 1'b1;
                        chain_valid_q <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ciphertext      = ciphertext_q;
    assign encryption_done = done_q;
    assign busy            = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign core_start      = core_start_q;
    assign core_key        = key_q;
    assign core_block_in   = block_q;

    always_comb begin
        status               = 8'h00;
        status[STAT_DONE]    = done_q;
        status[STAT_TIMEOUT] = timeout_q;
        status[STAT_OVERRUN] = overrun_q;
    end

endmodule
`default_nettype wire
